// File: rtl/layer_sched.sv
// ---------------------------------------------------------------------------
// layer_sched
//
// Multi-layer scheduler between the CPU configuration registers and the
// per-layer convolution controller. A run sequences cfg_n_layer layers
// back-to-back: each layer gets one lyr_start strobe with its kernel, input
// and output BRAM base addresses, and the scheduler then waits for lyr_done.
// Output features ping-pong between buffer A (obase) and buffer B
// (obase + fsize), so every layer reads what the previous layer wrote.
// One irq_done pulse marks the end of a complete run.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   cfg_start       : 1-cycle start request, accepted only when idle
//   cfg_abort       : 1-cycle cancel request, effective only when busy
//   cfg_n_layer     : layer count, latched on an accepted start
//   cfg_kbase       : kernel base address of layer 0
//   cfg_kstride     : kernel address step per layer
//   cfg_ibase       : input image address of layer 0
//   cfg_obase       : output buffer A base address
//   cfg_fsize       : feature buffer size (buffer B = obase + fsize)
//   lyr_start       : 1-cycle strobe to the per-layer controller
//   lyr_kaddr       : kernel address of the current layer
//   lyr_iaddr       : input feature address of the current layer
//   lyr_oaddr       : output feature address of the current layer
//   lyr_idx         : 0-based index of the current layer
//   lyr_last        : current layer is the final one
//   lyr_done        : per-layer completion pulse (honoured only while waiting)
//   busy            : high in every state except idle
//   irq_done        : 1-cycle pulse when the whole run has completed
//   aborted         : 1-cycle pulse when a run was cancelled
//
// All outputs are registered. Address arithmetic wraps modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module layer_sched #(
  parameter int ADDR_W  = 32,
  parameter int LAYER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [LAYER_W-1:0] cfg_n_layer,
  input  logic [ADDR_W-1:0]  cfg_kbase,
  input  logic [ADDR_W-1:0]  cfg_kstride,
  input  logic [ADDR_W-1:0]  cfg_ibase,
  input  logic [ADDR_W-1:0]  cfg_obase,
  input  logic [ADDR_W-1:0]  cfg_fsize,
  output logic               lyr_start,
  output logic [ADDR_W-1:0]  lyr_kaddr,
  output logic [ADDR_W-1:0]  lyr_iaddr,
  output logic [ADDR_W-1:0]  lyr_oaddr,
  output logic [LAYER_W-1:0] lyr_idx,
  output logic               lyr_last,
  input  logic               lyr_done,
  output logic               busy,
  output logic               irq_done,
  output logic               aborted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [LAYER_W-1:0] IDX_ZERO = {LAYER_W{1'b0}};
  localparam logic [LAYER_W-1:0] IDX_ONE  = {{(LAYER_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};

  state_t             state_r;
  // Index of the final layer (n_layer - 1); only meaningful for n_layer != 0.
  logic [LAYER_W-1:0] last_idx_r;
  logic [ADDR_W-1:0]  kstride_r;
  logic [ADDR_W-1:0]  obase_a_r;
  logic [ADDR_W-1:0]  obase_b_r;
  logic [LAYER_W-1:0] next_idx_s;

  // Index of the layer that follows the current one. The largest index ever
  // reached is n_layer - 1 <= 2^LAYER_W - 2, so this never wraps in a run.
  assign next_idx_s = lyr_idx + IDX_ONE;

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      last_idx_r <= IDX_ZERO;
      kstride_r  <= ADDR_ZERO;
      obase_a_r  <= ADDR_ZERO;
      obase_b_r  <= ADDR_ZERO;
      lyr_start  <= 1'b0;
      lyr_kaddr  <= ADDR_ZERO;
      lyr_iaddr  <= ADDR_ZERO;
      lyr_oaddr  <= ADDR_ZERO;
      lyr_idx    <= IDX_ZERO;
      lyr_last   <= 1'b0;
      busy       <= 1'b0;
      irq_done   <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      lyr_start <= 1'b0;
      irq_done  <= 1'b0;
      aborted   <= 1'b0;

      if ((state_r != S_IDLE) && cfg_abort) begin
        // Abort takes priority over everything, including a lyr_done in the
        // same cycle. Layer address outputs keep their last values.
        state_r <= S_IDLE;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (cfg_start) begin
              busy <= 1'b1;
              if (cfg_n_layer != IDX_ZERO) begin
                last_idx_r <= cfg_n_layer - IDX_ONE;
                kstride_r  <= cfg_kstride;
                obase_a_r  <= cfg_obase;
                obase_b_r  <= cfg_obase + cfg_fsize;
                lyr_idx    <= IDX_ZERO;
                lyr_kaddr  <= cfg_kbase;
                lyr_iaddr  <= cfg_ibase;
                lyr_oaddr  <= cfg_obase;
                lyr_last   <= (cfg_n_layer == IDX_ONE);
                lyr_start  <= 1'b1;
                state_r    <= S_ISSUE;
              end else begin
                // Empty run: no layer is issued. DONE is entered with
                // irq_done low and spends one settle cycle before the pulse.
                state_r <= S_DONE;
              end
            end else begin
              state_r <= S_IDLE;
            end
          end

          S_ISSUE: begin
            // lyr_start is high during this state only; lyr_done is ignored.
            state_r <= S_WAIT;
          end

          S_WAIT: begin
            if (lyr_done) begin
              if (lyr_last) begin
                irq_done <= 1'b1;
                state_r  <= S_DONE;
              end else begin
                state_r  <= S_ADVANCE;
              end
            end else begin
              state_r <= S_WAIT;
            end
          end

          S_ADVANCE: begin
            // Last layer's output becomes this layer's input; even layers
            // write buffer A, odd layers buffer B.
            lyr_idx   <= next_idx_s;
            lyr_kaddr <= lyr_kaddr + kstride_r;
            lyr_iaddr <= lyr_oaddr;
            lyr_oaddr <= next_idx_s[0] ? obase_b_r : obase_a_r;
            lyr_last  <= (next_idx_s == last_idx_r);
            lyr_start <= 1'b1;
            state_r   <= S_ISSUE;
          end

          S_DONE: begin
            if (irq_done) begin
              // The completion pulse has been shown for one cycle.
              busy    <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              irq_done <= 1'b1;
              state_r  <= S_DONE;
            end
          end

          default: begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_layer_sched
//
// Scoreboard bench for layer_sched. Stimulus pushes the hand-computed expected
// lyr_start events (cycle, addresses, index, last flag), irq_done cycles and
// aborted cycles into queues; a monitor on the falling edge pops and compares
// whenever the DUT raises one of those strobes. Any strobe with nothing
// expected is flagged, and all queues must be empty at the end.
// ---------------------------------------------------------------------------
module tb_layer_sched;

  localparam int AW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic          cfg_abort;
  logic [LW-1:0] cfg_n_layer;
  logic [AW-1:0] cfg_kbase;
  logic [AW-1:0] cfg_kstride;
  logic [AW-1:0] cfg_ibase;
  logic [AW-1:0] cfg_obase;
  logic [AW-1:0] cfg_fsize;
  logic          lyr_start;
  logic [AW-1:0] lyr_kaddr;
  logic [AW-1:0] lyr_iaddr;
  logic [AW-1:0] lyr_oaddr;
  logic [LW-1:0] lyr_idx;
  logic          lyr_last;
  logic          lyr_done;
  logic          busy;
  logic          irq_done;
  logic          aborted;

  layer_sched #(.ADDR_W(AW), .LAYER_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_n_layer(cfg_n_layer),
    .cfg_kbase(cfg_kbase), .cfg_kstride(cfg_kstride), .cfg_ibase(cfg_ibase),
    .cfg_obase(cfg_obase), .cfg_fsize(cfg_fsize),
    .lyr_start(lyr_start), .lyr_kaddr(lyr_kaddr), .lyr_iaddr(lyr_iaddr),
    .lyr_oaddr(lyr_oaddr), .lyr_idx(lyr_idx), .lyr_last(lyr_last),
    .lyr_done(lyr_done), .busy(busy), .irq_done(irq_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Cycle n is the period after rising edge n; inputs driven in cycle n are
  // sampled at edge n+1 and registered responses appear in cycle n+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] k;
    logic [AW-1:0] i;
    logic [AW-1:0] o;
    logic [LW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t sq[$];
  int   iq[$];
  int   aq[$];
  int   checks = 0;
  int   errs   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_s(input int c, input logic [AW-1:0] k, input logic [AW-1:0] i,
                        input logic [AW-1:0] o, input logic [LW-1:0] idx, input logic last);
    exp_t e;
    e.c = c; e.k = k; e.i = i; e.o = o; e.idx = idx; e.last = last;
    sq.push_back(e);
  endtask

  // Monitor: compare every DUT strobe against the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (lyr_start) begin
        if (sq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_lyr_start at cycle %0d: got idx %0d, expected none", cyc, lyr_idx);
        end else begin
          e = sq.pop_front();
          chk("start_cycle", 64'(cyc), 64'(e.c));
          chk("kaddr", 64'(lyr_kaddr), 64'(e.k));
          chk("iaddr", 64'(lyr_iaddr), 64'(e.i));
          chk("oaddr", 64'(lyr_oaddr), 64'(e.o));
          chk("idx", 64'(lyr_idx), 64'(e.idx));
          chk("last", 64'(lyr_last), 64'(e.last));
          chk("busy_at_start", 64'(busy), 64'd1);
        end
      end
      if (irq_done) begin
        if (iq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_irq_done at cycle %0d: got 1, expected 0", cyc);
        end else begin
          chk("irq_cycle", 64'(cyc), 64'(iq.pop_front()));
        end
      end
      if (aborted) begin
        if (aq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_aborted at cycle %0d: got 1, expected 0", cyc);
        end else begin
          chk("abort_cycle", 64'(cyc), 64'(aq.pop_front()));
          chk("busy_on_abort", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic done_at(input int c);
    goto(c);
    lyr_done = 1'b1;
    @(negedge clk);
    lyr_done = 1'b0;
  endtask

  task automatic cfg_set(input logic [LW-1:0] n, input logic [AW-1:0] kb, input logic [AW-1:0] ks,
                         input logic [AW-1:0] ib, input logic [AW-1:0] ob, input logic [AW-1:0] fs);
    cfg_n_layer = n; cfg_kbase = kb; cfg_kstride = ks;
    cfg_ibase = ib; cfg_obase = ob; cfg_fsize = fs;
  endtask

  task automatic start_now();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected run completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic [AW-1:0] ob;
    logic [AW-1:0] fs;
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; lyr_done = 1'b0;
    cfg_set(8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lyr_start", 64'(lyr_start), 64'd0);
    chk("rst_kaddr", 64'(lyr_kaddr), 64'd0);
    chk("rst_idx", 64'(lyr_idx), 64'd0);
    chk("rst_irq", 64'(irq_done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // lyr_done and cfg_abort while idle have no effect.
    lyr_done = 1'b1; cfg_abort = 1'b1;
    @(negedge clk);
    lyr_done = 1'b0; cfg_abort = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Three-layer run with ping-pong buffers.
    t = cyc;
    cfg_set(8'd3, 32'h100, 32'h40, 32'h1000, 32'h2000, 32'h800);
    push_s(t + 1,  32'h100, 32'h1000, 32'h2000, 8'd0, 1'b0);
    push_s(t + 8,  32'h140, 32'h2000, 32'h2800, 8'd1, 1'b0);
    push_s(t + 15, 32'h180, 32'h2800, 32'h2000, 8'd2, 1'b1);
    iq.push_back(t + 21);
    start_now();
    done_at(t + 6);
    done_at(t + 13);
    done_at(t + 20);
    goto(t + 21);
    chk("t1_busy_irq", 64'(busy), 64'd1);
    goto(t + 22);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_hold_k", 64'(lyr_kaddr), 64'h180);
    chk("t1_hold_idx", 64'(lyr_idx), 64'd2);
    goto(t + 24);

    // Zero-layer run.
    t = cyc;
    cfg_set(8'd0, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5);
    iq.push_back(t + 2);
    start_now();
    chk("t2_busy1", 64'(busy), 64'd1);
    goto(t + 2);
    chk("t2_busy2", 64'(busy), 64'd1);
    goto(t + 3);
    chk("t2_busy3", 64'(busy), 64'd0);
    goto(t + 5);

    // Abort together with the second lyr_done, then a fresh run.
    t = cyc;
    cfg_set(8'd4, 32'h300, 32'h8, 32'hA000, 32'hB000, 32'h400);
    push_s(t + 1, 32'h300, 32'hA000, 32'hB000, 8'd0, 1'b0);
    push_s(t + 8, 32'h308, 32'hB000, 32'hB400, 8'd1, 1'b0);
    aq.push_back(t + 14);
    start_now();
    done_at(t + 6);
    goto(t + 13);
    lyr_done = 1'b1; cfg_abort = 1'b1;
    @(negedge clk);
    lyr_done = 1'b0; cfg_abort = 1'b0;
    chk("t3_busy_abort", 64'(busy), 64'd0);
    goto(t + 20);
    t = cyc;
    cfg_set(8'd1, 32'h900, 32'h4, 32'h1111_0000, 32'h2222_0000, 32'h10);
    push_s(t + 1, 32'h900, 32'h1111_0000, 32'h2222_0000, 8'd0, 1'b1);
    iq.push_back(t + 7);
    start_now();
    done_at(t + 6);
    goto(t + 9);

    // Second start during WAIT with different configuration is ignored.
    t = cyc;
    cfg_set(8'd2, 32'h4000, 32'h10, 32'h5000, 32'h6000, 32'h100);
    push_s(t + 1, 32'h4000, 32'h5000, 32'h6000, 8'd0, 1'b0);
    push_s(t + 8, 32'h4010, 32'h6000, 32'h6100, 8'd1, 1'b1);
    iq.push_back(t + 14);
    start_now();
    goto(t + 3);
    cfg_set(8'd5, 32'hDEAD_0000, 32'h1000, 32'hBEEF_0000, 32'hCAFE_0000, 32'h2000);
    start_now();
    done_at(t + 6);
    done_at(t + 13);
    goto(t + 16);

    // Kernel address wrap; lyr_done in the ISSUE cycle is ignored.
    t = cyc;
    cfg_set(8'd2, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h100, 32'h10);
    push_s(t + 1, 32'hFFFF_FFF0, 32'h0, 32'h100, 8'd0, 1'b0);
    push_s(t + 8, 32'h0000_0010, 32'h100, 32'h110, 8'd1, 1'b1);
    iq.push_back(t + 14);
    start_now();
    done_at(t + 1);
    done_at(t + 6);
    done_at(t + 13);
    goto(t + 16);

    // Asynchronous reset in the middle of WAIT.
    t = cyc;
    cfg_set(8'd2, 32'h40, 32'h4, 32'h700, 32'h800, 32'h80);
    push_s(t + 1, 32'h40, 32'h700, 32'h800, 8'd0, 1'b0);
    start_now();
    goto(t + 3);
    #1 rst = 1'b1;
    #1;
    chk("arst_kaddr", 64'(lyr_kaddr), 64'd0);
    chk("arst_iaddr", 64'(lyr_iaddr), 64'd0);
    chk("arst_oaddr", 64'(lyr_oaddr), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_at(t + 6);
    goto(t + 16);
    chk("arst_idle_busy", 64'(busy), 64'd0);

    // Maximum layer count: 255 layers, indices 0..254.
    t = cyc;
    ob = 32'h8000_0000;
    fs = 32'h100;
    cfg_set(8'd255, 32'h0, 32'h3, 32'h7000_0000, ob, fs);
    for (int i = 0; i < 255; i++) begin
      push_s(t + 1 + 7 * i, 32'(3 * i),
             (i == 0) ? 32'h7000_0000 : ((((i - 1) % 2) == 0) ? ob : ob + fs),
             ((i % 2) == 0) ? ob : ob + fs, 8'(i), (i == 254));
    end
    iq.push_back(t + 7 + 7 * 254);
    start_now();
    for (int i = 0; i < 255; i++) done_at(t + 6 + 7 * i);
    goto(t + 9 + 7 * 254);
    chk("max_busy_end", 64'(busy), 64'd0);

    goto(cyc + 5);
    chk("start_q_empty", 64'(sq.size()), 64'd0);
    chk("irq_q_empty", 64'(iq.size()), 64'd0);
    chk("abort_q_empty", 64'(aq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
